// File: rtl/rom_arbiter_ahb_pkg.sv
// Shared configuration types for the boot/config ROM arbiter.
// cvw_t carries the core address and data widths.
package rom_arbiter_ahb_pkg;

  typedef struct packed {
    int unsigned PA_BITS;
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t CvwDefault = '{PA_BITS: 32, XLEN: 64};

endpackage

// File: rtl/rom_arbiter_ahb_rr_arb2.sv
// Two-requester round-robin arbiter. A valid priority request always wins.
// last_q remembers the most recent winner so that a tie goes to the other port.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       prio_valid_i,
  input  logic       prio_id_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    if (prio_valid_i) begin
      grant_o = prio_id_i ? 2'b10 : 2'b01;
    end else if (&req_i) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (|grant_o) last_d = grant_o[1];
  end

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rom_arbiter_ahb.sv
// Shares one single-ported, 1-cycle-latency ROM between two AHB-Lite read ports.
// Uncontested reads are zero-wait; a collision costs the loser exactly one wait state.
module rom_arbiter_ahb
  import rom_arbiter_ahb_pkg::*;
#(
  parameter cvw_t        P     = CvwDefault,
  parameter int unsigned RANGE = 65535
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL0,
  input  logic [P.PA_BITS-1:0] HADDR0,
  input  logic [1:0]           HTRANS0,
  input  logic                 HWRITE0,
  input  logic                 HREADY0,
  output logic                 HREADYOUT0,
  output logic                 HRESP0,
  output logic [P.XLEN-1:0]    HRDATA0,
  input  logic                 HSEL1,
  input  logic [P.PA_BITS-1:0] HADDR1,
  input  logic [1:0]           HTRANS1,
  input  logic                 HWRITE1,
  input  logic                 HREADY1,
  output logic                 HREADYOUT1,
  output logic                 HRESP1,
  output logic [P.XLEN-1:0]    HRDATA1,
  output logic                 RomCE,
  output logic [$clog2(RANGE/8)-1:0] RomAddr,
  input  logic [P.XLEN-1:0]    RomDout
);

  localparam int unsigned ADDR_WIDTH = $clog2(RANGE / 8);
  localparam int unsigned OFFSET     = $clog2(P.XLEN / 8);

  logic [1:0]            req;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] word_addr0, word_addr1;

  logic                  pend_q, pend_d;
  logic                  pend_port_q, pend_port_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]            data_phase_q, data_phase_d;

  // Writes and IDLE/BUSY transfers never reach the ROM.
  assign req[0] = HSEL0 & HREADY0 & HTRANS0[1] & ~HWRITE0;
  assign req[1] = HSEL1 & HREADY1 & HTRANS1[1] & ~HWRITE1;

  assign word_addr0 = HADDR0[ADDR_WIDTH+OFFSET-1:OFFSET];
  assign word_addr1 = HADDR1[ADDR_WIDTH+OFFSET-1:OFFSET];

  rr_arb2 u_arb (
    .clk_i        (HCLK),
    .rst_ni       (HRESETn),
    .req_i        (req),
    .prio_valid_i (pend_q),
    .prio_id_i    (pend_port_q),
    .grant_o      (grant)
  );

  always_comb begin
    pend_d       = pend_q;
    pend_port_d  = pend_port_q;
    pend_addr_d  = pend_addr_q;
    data_phase_d = grant;
    if (pend_q && grant[pend_port_q]) pend_d = 1'b0;
    // A losing new request parks its address; the pending port is stalled so
    // at most one of these can fire in a cycle.
    if (req[0] && !grant[0]) begin
      pend_d      = 1'b1;
      pend_port_d = 1'b0;
      pend_addr_d = word_addr0;
    end
    if (req[1] && !grant[1]) begin
      pend_d      = 1'b1;
      pend_port_d = 1'b1;
      pend_addr_d = word_addr1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q       <= 1'b0;
      pend_port_q  <= 1'b0;
      pend_addr_q  <= '0;
      data_phase_q <= 2'b00;
    end else begin
      pend_q       <= pend_d;
      pend_port_q  <= pend_port_d;
      pend_addr_q  <= pend_addr_d;
      data_phase_q <= data_phase_d;
    end
  end

  always_comb begin
    if (pend_q) begin
      RomAddr = pend_addr_q;
    end else if (grant[1]) begin
      RomAddr = word_addr1;
    end else begin
      RomAddr = word_addr0;
    end
  end

  // Grant is combinational from the bus, so gate it to keep the ROM quiet in reset.
  assign RomCE = HRESETn & (|grant);

  assign HREADYOUT0 = ~(pend_q & ~pend_port_q);
  assign HREADYOUT1 = ~(pend_q & pend_port_q);
  assign HRESP0     = 1'b0;
  assign HRESP1     = 1'b0;
  assign HRDATA0    = RomDout;
  assign HRDATA1    = RomDout;

  logic unused_bits;
  assign unused_bits = ^{HTRANS0[0], HTRANS1[0], HADDR0, HADDR1};

  a_single_pending: assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(pend_q && req[pend_port_q]));

  a_data_phase_ready: assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(|(data_phase_q & {pend_q & pend_port_q, pend_q & ~pend_port_q})));

endmodule

// File: tb/tb_rom_arbiter_ahb.sv
// Directed bench for rom_arbiter_ahb with a behavioural 1-cycle ROM macro.
module tb_rom_arbiter_ahb;
  import rom_arbiter_ahb_pkg::*;

  localparam cvw_t P = '{PA_BITS: 32, XLEN: 64};
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL0, HSEL1, HWRITE0, HWRITE1;
  logic [31:0] HADDR0, HADDR1;
  logic [1:0]  HTRANS0, HTRANS1;
  logic        HREADY0, HREADY1, HREADYOUT0, HREADYOUT1, HRESP0, HRESP1;
  logic [63:0] HRDATA0, HRDATA1, RomDout;
  logic        RomCE;
  logic [12:0] RomAddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  // Single subordinate on each bus: HREADY is the subordinate's own HREADYOUT.
  assign HREADY0 = HREADYOUT0;
  assign HREADY1 = HREADYOUT1;

  rom_arbiter_ahb #(.P(P), .RANGE(65535)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL0      (HSEL0),
    .HADDR0     (HADDR0),
    .HTRANS0    (HTRANS0),
    .HWRITE0    (HWRITE0),
    .HREADY0    (HREADY0),
    .HREADYOUT0 (HREADYOUT0),
    .HRESP0     (HRESP0),
    .HRDATA0    (HRDATA0),
    .HSEL1      (HSEL1),
    .HADDR1     (HADDR1),
    .HTRANS1    (HTRANS1),
    .HWRITE1    (HWRITE1),
    .HREADY1    (HREADY1),
    .HREADYOUT1 (HREADYOUT1),
    .HRESP1     (HRESP1),
    .HRDATA1    (HRDATA1),
    .RomCE      (RomCE),
    .RomAddr    (RomAddr),
    .RomDout    (RomDout)
  );

  function automatic logic [63:0] rom_word(input logic [12:0] a);
    return {16'hB007, 3'b000, a, 16'hC0F1, 3'b000, ~a};
  endfunction

  always @(posedge HCLK) begin
    if (RomCE) RomDout <= rom_word(RomAddr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a);
    HSEL0 = sel; HTRANS0 = tr; HWRITE0 = wr; HADDR0 = a;
  endtask

  task automatic drv1(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a);
    HSEL1 = sel; HTRANS1 = tr; HWRITE1 = wr; HADDR1 = a;
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    drv0(1'b0, ID, 1'b0, 32'h0);
    drv1(1'b0, ID, 1'b0, 32'h0);
    #12;
    chk("rst_rdy0", HREADYOUT0, 1);
    chk("rst_rdy1", HREADYOUT1, 1);
    chk("rst_resp0", HRESP0, 0);
    chk("rst_resp1", HRESP1, 0);
    chk("rst_ce", RomCE, 0);
    tick;
    HRESETn = 1'b1;

    // Solo back-to-back reads on port 0.
    tick; drv0(1'b1, NS, 1'b0, 32'h0); #3;
    chk("solo_ce", RomCE, 1);
    chk("solo_addr0", RomAddr, 0);
    chk("solo_rdy0_a", HREADYOUT0, 1);
    tick; drv0(1'b1, NS, 1'b0, 32'h8); #3;
    chk("solo_addr1", RomAddr, 1);
    chk("solo_data0", HRDATA0, rom_word(13'd0));
    chk("solo_rdy0_b", HREADYOUT0, 1);
    tick; drv0(1'b1, NS, 1'b0, 32'h10); #3;
    chk("solo_addr2", RomAddr, 2);
    chk("solo_data1", HRDATA0, rom_word(13'd1));
    tick; drv0(1'b0, ID, 1'b0, 32'h0); #3;
    chk("solo_data2", HRDATA0, rom_word(13'd2));
    chk("solo_idle_ce", RomCE, 0);
    chk("solo_rdy0_c", HREADYOUT0, 1);

    // Reset so the first tie is decided by the reset value of Last.
    tick; HRESETn = 1'b0; #2; HRESETn = 1'b1;

    // First collision after reset: port 0 wins, port 1 waits one cycle.
    tick; drv0(1'b1, NS, 1'b0, 32'h20); drv1(1'b1, NS, 1'b0, 32'h40); #3;
    chk("col_addr_p0", RomAddr, 4);
    chk("col_rdy1_a", HREADYOUT1, 1);
    tick; drv0(1'b0, ID, 1'b0, 32'h0); #3;
    chk("col_rdy1_wait", HREADYOUT1, 0);
    chk("col_addr_p1", RomAddr, 8);
    chk("col_ce_p1", RomCE, 1);
    chk("col_data0", HRDATA0, rom_word(13'd4));
    chk("col_rdy0", HREADYOUT0, 1);
    tick; drv1(1'b0, ID, 1'b0, 32'h0); #3;
    chk("col_data1", HRDATA1, rom_word(13'd8));
    chk("col_rdy1_b", HREADYOUT1, 1);
    chk("col_idle_ce", RomCE, 0);

    // Sustained collisions: grants alternate 0,1,0,1,0,1.
    tick; drv0(1'b1, NS, 1'b0, 32'h80); drv1(1'b1, NS, 1'b0, 32'h100); #3;
    chk("rr1_addr", RomAddr, 16);
    tick; drv0(1'b1, NS, 1'b0, 32'h88); #3;
    chk("rr2_addr_pend1_first", RomAddr, 32);
    chk("rr2_rdy1", HREADYOUT1, 0);
    chk("rr2_data0", HRDATA0, rom_word(13'd16));
    tick; drv1(1'b1, NS, 1'b0, 32'h108); #3;
    chk("rr3_addr_pend0", RomAddr, 17);
    chk("rr3_rdy0", HREADYOUT0, 0);
    chk("rr3_data1", HRDATA1, rom_word(13'd32));
    chk("rr3_rdy1", HREADYOUT1, 1);
    tick; drv0(1'b1, NS, 1'b0, 32'h90); #3;
    chk("rr4_addr", RomAddr, 33);
    chk("rr4_data0", HRDATA0, rom_word(13'd17));
    chk("rr4_rdy0", HREADYOUT0, 1);
    tick; drv1(1'b1, NS, 1'b0, 32'h110); #3;
    chk("rr5_addr", RomAddr, 18);
    chk("rr5_data1", HRDATA1, rom_word(13'd33));
    tick; drv0(1'b0, ID, 1'b0, 32'h0); #3;
    chk("rr6_addr", RomAddr, 34);
    chk("rr6_data0", HRDATA0, rom_word(13'd18));
    tick; drv1(1'b0, ID, 1'b0, 32'h0); #3;
    chk("rr7_data1", HRDATA1, rom_word(13'd34));
    chk("rr7_ce", RomCE, 0);

    // Write on port 1: no ROM access, zero-wait OKAY, then read back.
    tick; drv1(1'b1, NS, 1'b1, 32'h18); #3;
    chk("wr_ce", RomCE, 0);
    chk("wr_rdy1", HREADYOUT1, 1);
    chk("wr_resp1", HRESP1, 0);
    tick; drv1(1'b1, NS, 1'b0, 32'h18); #3;
    chk("rb_addr", RomAddr, 3);
    chk("rb_rdy1", HREADYOUT1, 1);
    tick; drv1(1'b0, ID, 1'b0, 32'h0); #3;
    chk("rb_data1", HRDATA1, rom_word(13'd3));

    // Reset while port 1 is pending.
    tick; drv0(1'b1, NS, 1'b0, 32'h20); drv1(1'b1, NS, 1'b0, 32'h40); #3;
    chk("rp_addr_p0", RomAddr, 4);
    tick; drv0(1'b0, ID, 1'b0, 32'h0); #1;
    chk("rp_pending", HREADYOUT1, 0);
    HRESETn = 1'b0; #1;
    chk("rp_rdy1_async", HREADYOUT1, 1);
    chk("rp_ce_in_rst", RomCE, 0);
    drv1(1'b0, ID, 1'b0, 32'h0);
    tick; HRESETn = 1'b1; #3;
    chk("rp_no_ce_after", RomCE, 0);
    tick; drv0(1'b1, NS, 1'b0, 32'h20); drv1(1'b1, NS, 1'b0, 32'h40); #3;
    chk("rp_tie_p0", RomAddr, 4);
    chk("rp_tie_ce", RomCE, 1);
    tick; drv0(1'b0, ID, 1'b0, 32'h0); #3;
    chk("rp_tie_wait1", HREADYOUT1, 0);
    chk("rp_tie_addr_p1", RomAddr, 8);
    tick; drv1(1'b0, ID, 1'b0, 32'h0); #3;
    chk("rp_tie_data1", HRDATA1, rom_word(13'd8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
